custom_subtractor48_4_serial: RTL and testbench

Digit-serial subtractor: it takes a 48-bit value `A`, subtracts a zero-extended 4-bit value `B`, and returns a 47-bit difference with underflow/overflow flags. It is the inverse path of the 47+4 → 48-bit custom adder in the floating-point datapath. It undoes a small increment (rounding or exponent adjust) on a widened significand. It spends one cycle per 4-bit digit to keep area low, and uses valid/ready handshakes on both sides.

---
 rtl/custom_subtractor48_4_serial.sv | 151 +++++++++++++++
 tb/tb_custom_subtractor48_4_serial.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/custom_subtractor48_4_serial.sv
// custom_subtractor48_4_serial
//
// Digit-serial subtractor: Diff = low (WIDTH_A-1) bits of A - {0,B} mod 2^WIDTH_A.
// It undoes a small increment on a widened significand, one DIGIT-bit digit
// per clock, least-significant digit first. Every operation takes exactly
// NDIG RUN cycles, whatever the data.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands presented          / in_ready  accepting (IDLE)
//   A          minuend, WIDTH_A bits
//   B          subtrahend, WIDTH_B bits, zero-extended to WIDTH_A
//   out_valid  result available (DONE)     / out_ready consumer takes result
//   Diff       low WIDTH_A-1 bits of the difference (registered, held)
//   underflow  A < B, so the result wrapped
//   overflow   no underflow, but result MSB is set (does not fit WIDTH_A-1)
module custom_subtractor48_4_serial #(
  parameter int WIDTH_A = 48,
  parameter int WIDTH_B = 4,
  parameter int DIGIT   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] A,
  input  logic [WIDTH_B-1:0] B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_A-2:0] Diff,
  output logic               underflow,
  output logic               overflow
);

  localparam int NDIG  = WIDTH_A / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH_A-1:0] a_q, a_d;
  logic [WIDTH_A-1:0] b_q, b_d;
  logic [WIDTH_A-1:0] res_q, res_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH_A-2:0] diff_q, diff_d;
  logic               uf_q, uf_d;
  logic               of_q, of_d;

  // One digit of the subtraction; the extra top bit is the borrow out.
  logic [DIGIT:0]     digit;
  logic [WIDTH_A-1:0] res_shift;
  logic               last_digit;

  assign digit = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
               - {{DIGIT{1'b0}}, borrow_q};
  // Digits arrive LSB first, so each new one enters at the top and the
  // register has shifted into final position after NDIG digits.
  assign res_shift  = {digit[DIGIT-1:0], res_q[WIDTH_A-1:DIGIT]};
  assign last_digit = (cnt_q == CNT_W'(NDIG - 1));

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      uf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      uf_q     <= uf_d;
      of_q     <= of_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid)   state_d = S_RUN;
      S_RUN:   if (last_digit) state_d = S_DONE;
      S_DONE:  if (out_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    uf_d     = uf_q;
    of_d     = of_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = {{(WIDTH_A-WIDTH_B){1'b0}}, B};
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        res_d    = res_shift;
        borrow_d = digit[DIGIT];
        cnt_d    = cnt_q + CNT_W'(1);
        // Outputs are captured only at the final digit, so they keep the
        // previous result until a new one is complete.
        if (last_digit) begin
          diff_d = res_shift[WIDTH_A-2:0];
          uf_d   = digit[DIGIT];
          of_d   = ~digit[DIGIT] & res_shift[WIDTH_A-1];
        end
      end
      default: ;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    Diff      = diff_q;
    underflow = uf_q;
    overflow  = of_q;
  end

endmodule

// File: tb/tb_custom_subtractor48_4_serial.sv
module tb_custom_subtractor48_4_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] A;
  logic [3:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [46:0] Diff;
  logic        underflow;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  typedef struct packed {
    logic [46:0] diff;
    logic        uf;
    logic        of;
  } exp_t;

  exp_t sb_q[$];

  custom_subtractor48_4_serial #(
    .WIDTH_A(48), .WIDTH_B(4), .DIGIT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .underflow (underflow),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Monitor: consumes one expected entry per output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output diff=%h uf=%b of=%b (no result expected)",
                 Diff, underflow, overflow);
      end else if (out_ready) begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        txn++;
        if (Diff !== e.diff || underflow !== e.uf || overflow !== e.of) begin
          errors++;
          $display("FAIL result txn %0d: got diff=%h uf=%b of=%b, want diff=%h uf=%b of=%b",
                   txn, Diff, underflow, overflow, e.diff, e.uf, e.of);
        end else begin
          $display("txn %0d diff=%h uf=%b of=%b ok", txn, Diff, underflow, overflow);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Present operands for one accept edge; optionally record the expected result.
  task automatic issue(input logic [47:0] a, input logic [3:0] b, input bit push,
                       input logic [46:0] ed, input logic euf, input logic eof);
    exp_t e;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    if (push) begin
      e.diff = ed; e.uf = euf; e.of = eof;
      sb_q.push_back(e);
    end
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd12);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_after_handshake", 64'(n), 64'd1);
  endtask

  task automatic run_op(input logic [47:0] a, input logic [3:0] b,
                        input logic [46:0] ed, input logic euf, input logic eof);
    issue(a, b, 1'b1, ed, euf, eof);
    wait_out();
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_diff",      64'(Diff),      64'd0);
    chk("rst_underflow", 64'(underflow), 64'd0);
    chk("rst_overflow",  64'(overflow),  64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic, borrow ripple, underflow, overflow and a few extra patterns
    run_op(48'h0000_0000_0010, 4'h3, 47'h0000_0000_000D, 1'b0, 1'b0);
    chk("diff_held_in_idle", 64'(Diff), 64'hD);
    run_op(48'h1000_0000_0000, 4'h1, 47'h0FFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op(48'h0000_0000_0000, 4'h1, 47'h7FFF_FFFF_FFFF, 1'b1, 1'b0);
    run_op(48'h8000_0000_0005, 4'h5, 47'h0000_0000_0000, 1'b0, 1'b1);
    run_op(48'hFFFF_FFFF_FFFF, 4'hF, 47'h7FFF_FFFF_FFF0, 1'b0, 1'b1);
    run_op(48'h0000_0000_0005, 4'h5, 47'h0000_0000_0000, 1'b0, 1'b0);
    run_op(48'h0000_0000_0003, 4'hF, 47'h7FFF_FFFF_FFF4, 1'b1, 1'b0);

    // Backpressure: result held 5 cycles, new operands ignored meanwhile
    out_ready = 1'b0;
    issue(48'h1234_5678_9ABC, 4'hC, 1'b1, 47'h1234_5678_9AB0, 1'b0, 1'b0);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      A = 48'h0000_0000_0777; B = 4'h1; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      chk("bp_diff",      64'(Diff),      64'h1234_5678_9AB0);
      chk("bp_flags",     64'({underflow, overflow}), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready",  64'(in_ready),  64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);

    // Reset after 6 digits: operation abandoned
    issue(48'hABCD_EF01_2345, 4'h7, 1'b0, 47'h0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midrun_rst_in_ready",  64'(in_ready),  64'd1);
    chk("midrun_rst_diff",      64'(Diff),      64'd0);
    chk("midrun_rst_flags",     64'({underflow, overflow}), 64'd0);
    rst = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("abandoned_no_output", 64'(out_valid), 64'd0);
    chk("abandoned_in_ready",  64'(in_ready),  64'd1);

    run_op(48'h0000_0000_0020, 4'hF, 47'h0000_0000_0011, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    chk("results_seen",     64'(txn),         64'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
